fetch_unit: RTL and testbench

Program-counter and flash-fetch stage that sits directly upstream of the control unit. It holds the 12-bit PC and issues byte reads to program flash over a req/ack handshake. It presents each fetched byte to the control unit with a one-cycle valid strobe. It advances or redirects the PC on the control unit's `pc_inc` / `pc_load` / `pc_next` requests.

---
 rtl/fetch_pkg.sv | 15 +
 rtl/fetch_unit.sv | 99 +++++++++
 tb/tb_fetch_unit.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// Shared types and defaults for the program-counter / flash-fetch stage.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package fetch_pkg;

  localparam int unsigned ADDR_W_DEF = 12;
  localparam logic [ADDR_W_DEF-1:0] RESET_PC_DEF = 12'h000;

  typedef enum logic [1:0] {
    RST_ST = 2'd0,
    FETCH  = 2'd1,
    HOLD   = 2'd2
  } fetch_state_t;

endpackage

// File: rtl/fetch_unit.sv
// PC register plus flash byte fetch; hands each byte to the control unit with a 1-cycle strobe.
// Latency: ack in cycle N gives flash_data/byte_valid in N+1; pc_inc/pc_load in HOLD gives new pc and flash_req in the next cycle.
// Backpressure: flash may stall ack indefinitely (request held stable); control unit paces fetches via pc_inc/pc_load in HOLD.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF,
  parameter logic [ADDR_W-1:0] RESET_PC = RESET_PC_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pc_inc,
  input  logic              pc_load,
  input  logic [ADDR_W-1:0] pc_next,
  output logic              flash_req,
  output logic [ADDR_W-1:0] flash_addr,
  input  logic              flash_ack,
  input  logic [7:0]        flash_rdata,
  output logic [7:0]        flash_data,
  output logic              byte_valid,
  output logic [ADDR_W-1:0] pc,
  output logic              busy
);

  fetch_state_t      state, state_nxt;
  logic [ADDR_W-1:0] pc_nxt;
  logic [7:0]        data_nxt;
  logic              valid_nxt;
  logic              redir_pend, redir_pend_nxt;
  logic [ADDR_W-1:0] redir_addr, redir_addr_nxt;

  // State and datapath registers; reset abandons any in-flight flash read.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= RST_ST;
      pc         <= RESET_PC;
      flash_data <= 8'h00;
      byte_valid <= 1'b0;
      redir_pend <= 1'b0;
      redir_addr <= '0;
    end else begin
      state      <= state_nxt;
      pc         <= pc_nxt;
      flash_data <= data_nxt;
      byte_valid <= valid_nxt;
      redir_pend <= redir_pend_nxt;
      redir_addr <= redir_addr_nxt;
    end
  end

  // Next-state logic: a redirect seen during a fetch is parked until the
  // flash answers, so the address stays stable for the whole transaction.
  always_comb begin
    state_nxt      = state;
    pc_nxt         = pc;
    data_nxt       = flash_data;
    valid_nxt      = 1'b0;
    redir_pend_nxt = redir_pend;
    redir_addr_nxt = redir_addr;
    case (state)
      RST_ST: begin
        state_nxt = FETCH;
      end
      FETCH: begin
        if (flash_ack) begin
          if (redir_pend || pc_load) begin
            // Stale byte: drop it and restart at the redirect target.
            pc_nxt         = pc_load ? pc_next : redir_addr;
            redir_pend_nxt = 1'b0;
          end else begin
            data_nxt  = flash_rdata;
            valid_nxt = 1'b1;
            state_nxt = HOLD;
          end
        end else if (pc_load) begin
          redir_addr_nxt = pc_next;
          redir_pend_nxt = 1'b1;
        end
      end
      HOLD: begin
        if (pc_load) begin
          pc_nxt    = pc_next;
          state_nxt = FETCH;
        end else if (pc_inc) begin
          pc_nxt    = pc + ADDR_W'(1);
          state_nxt = FETCH;
        end
      end
      default: begin
        state_nxt = RST_ST;
      end
    endcase
  end

  assign flash_req  = (state == FETCH);
  assign flash_addr = pc;
  assign busy       = (state != HOLD);

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit with hand-computed expectations.
// Inputs change 1ns after each rising edge; outputs are checked at the same point.
// Runs a fixed number of cycles; no open-ended waits.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        pc_inc;
  logic        pc_load;
  logic [11:0] pc_next;
  logic        flash_req;
  logic [11:0] flash_addr;
  logic        flash_ack;
  logic [7:0]  flash_rdata;
  logic [7:0]  flash_data;
  logic        byte_valid;
  logic [11:0] pc;
  logic        busy;

  int checks = 0;
  int errors = 0;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .pc_inc      (pc_inc),
    .pc_load     (pc_load),
    .pc_next     (pc_next),
    .flash_req   (flash_req),
    .flash_addr  (flash_addr),
    .flash_ack   (flash_ack),
    .flash_rdata (flash_rdata),
    .flash_data  (flash_data),
    .byte_valid  (byte_valid),
    .pc          (pc),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // In FETCH at addr: hold ack low for 'delay' cycles (request must stay
  // stable), then ack with rdata and expect the byte in HOLD next cycle.
  task automatic fetch_byte(input int delay, input logic [7:0] rdata, input logic [11:0] addr);
    for (int i = 0; i < delay; i++) begin
      check("wait_req", {15'd0, flash_req}, 16'd1);
      check("wait_addr", {4'd0, flash_addr}, {4'd0, addr});
      tick();
    end
    check("ack_addr", {4'd0, flash_addr}, {4'd0, addr});
    flash_ack   = 1'b1;
    flash_rdata = rdata;
    tick();
    flash_ack   = 1'b0;
    flash_rdata = 8'h00;
    check("bv_pulse", {15'd0, byte_valid}, 16'd1);
    check("data", {8'd0, flash_data}, {8'd0, rdata});
    check("hold_req", {15'd0, flash_req}, 16'd0);
    check("hold_busy", {15'd0, busy}, 16'd0);
  endtask

  initial begin
    rst = 1'b1; pc_inc = 1'b0; pc_load = 1'b0; pc_next = '0;
    flash_ack = 1'b0; flash_rdata = '0;
    tick();
    tick();
    // Reset state
    check("rst_pc", {4'd0, pc}, 16'h0000);
    check("rst_req", {15'd0, flash_req}, 16'd0);
    check("rst_busy", {15'd0, busy}, 16'd1);
    check("rst_bv", {15'd0, byte_valid}, 16'd0);
    check("rst_data", {8'd0, flash_data}, 16'd0);

    // Release: RST_ST this cycle, FETCH the next
    rst = 1'b0;
    check("rst_st_req", {15'd0, flash_req}, 16'd0);
    tick();
    check("first_req", {15'd0, flash_req}, 16'd1);
    check("first_addr", {4'd0, flash_addr}, 16'h0000);
    fetch_byte(0, 8'hA5, 12'h000);
    tick();
    check("bv_one_cycle", {15'd0, byte_valid}, 16'd0);
    check("data_held", {8'd0, flash_data}, 16'h00A5);

    // Sequential fetch 0..3 with 3-cycle ack delay
    pc_load = 1'b1; pc_next = 12'h000;
    tick();
    pc_load = 1'b0;
    fetch_byte(3, 8'h10, 12'h000);
    for (int a = 1; a < 4; a++) begin
      pc_inc = 1'b1;
      tick();
      pc_inc = 1'b0;
      check("inc_pc", {4'd0, pc}, 16'(a));
      fetch_byte(3, 8'(8'h10 + a), 12'(a));
    end

    // Wrap at 12'hFFF
    pc_load = 1'b1; pc_next = 12'hFFF;
    tick();
    pc_load = 1'b0;
    check("load_fff", {4'd0, pc}, 16'h0FFF);
    fetch_byte(0, 8'h5A, 12'hFFF);
    pc_inc = 1'b1;
    tick();
    pc_inc = 1'b0;
    check("wrap_pc", {4'd0, pc}, 16'h0000);
    check("wrap_addr", {4'd0, flash_addr}, 16'h0000);
    check("wrap_req", {15'd0, flash_req}, 16'd1);

    // Redirect two cycles before ack
    pc_load = 1'b1; pc_next = 12'h123;
    tick();
    pc_load = 1'b0;
    check("redir_addr_stable", {4'd0, flash_addr}, 16'h0000);
    check("redir_bv", {15'd0, byte_valid}, 16'd0);
    tick();
    flash_ack = 1'b1; flash_rdata = 8'hEE;
    tick();
    flash_ack = 1'b0;
    check("redir_drop_bv", {15'd0, byte_valid}, 16'd0);
    check("redir_data_kept", {8'd0, flash_data}, 16'h005A);
    check("redir_pc", {4'd0, pc}, 16'h0123);
    check("redir_req", {15'd0, flash_req}, 16'd1);
    fetch_byte(1, 8'h77, 12'h123);

    // Same-cycle load in HOLD-issued fetch: ack and pc_load together
    pc_load = 1'b1; pc_next = 12'h200;
    tick();
    check("hold_load_pc", {4'd0, pc}, 16'h0200);
    flash_ack = 1'b1; flash_rdata = 8'h44; pc_next = 12'h300;
    tick();
    flash_ack = 1'b0; pc_load = 1'b0;
    check("ack_load_bv", {15'd0, byte_valid}, 16'd0);
    check("ack_load_pc", {4'd0, pc}, 16'h0300);
    fetch_byte(0, 8'h33, 12'h300);

    // inc + load together in HOLD: load wins
    pc_inc = 1'b1; pc_load = 1'b1; pc_next = 12'h040;
    tick();
    pc_load = 1'b0;
    check("both_pc", {4'd0, pc}, 16'h0040);
    check("both_req", {15'd0, flash_req}, 16'd1);
    // pc_inc still high in FETCH: ignored
    tick();
    pc_inc = 1'b0;
    check("fetch_inc_ignored", {4'd0, pc}, 16'h0040);

    // Reset mid-FETCH with a late ack during reset
    rst = 1'b1;
    tick();
    flash_ack = 1'b1; flash_rdata = 8'h99;
    check("midrst_bv0", {15'd0, byte_valid}, 16'd0);
    tick();
    flash_ack = 1'b0;
    rst = 1'b0;
    check("midrst_bv1", {15'd0, byte_valid}, 16'd0);
    check("midrst_pc", {4'd0, pc}, 16'h0000);
    check("midrst_data", {8'd0, flash_data}, 16'h0000);
    check("midrst_req", {15'd0, flash_req}, 16'd0);
    check("midrst_busy", {15'd0, busy}, 16'd1);
    tick();
    check("restart_req", {15'd0, flash_req}, 16'd1);
    check("restart_addr", {4'd0, flash_addr}, 16'h0000);
    fetch_byte(2, 8'hC3, 12'h000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
